// File: rtl/spi_reg_controller_if.sv
// Host-side request/status bundle for spi_reg_controller.
// The master modport is the host, the slave modport is the controller.
interface spi_reg_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       done;
  logic       busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, done, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, done, busy
  );
endinterface

// File: rtl/spi_reg_controller.sv
// Mode-0 SPI write controller: serializes {1, addr[6:0], data[7:0]} MSB first per host request.
// Optional full-duplex capture of the data byte on cipo when SPI_CTRL_READBACK_EN is defined.
module spi_reg_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_controller_if.slave  host,
`ifdef SPI_CTRL_READBACK_EN
  input  logic                 cipo,
  output logic [7:0]           rd_data,
`endif
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 copi
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  // Counters are loaded with duration-1 and the state moves on when they reach zero.
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_LD  = 8'(CS_IDLE - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        done_q, done_d;

  logic accept;
  logic cnt_zero;
  logic frame_active;

  assign accept       = (state_q == ST_IDLE) && host.req_valid;
  assign cnt_zero     = (cnt_q == 8'd0);
  assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT_HI) ||
                        (state_q == ST_SHIFT_LO) || (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          bit_d   = 4'd15;
          shreg_d = {1'b1, host.req_addr, host.req_data};
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_SHIFT_HI;
          cnt_d   = DIV_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (cnt_zero) begin
          state_d = ST_SHIFT_LO;
          cnt_d   = DIV_LD;
          // Next bit appears as sclk falls; bit 0 stays on copi through HOLD.
          if (bit_q != 4'd0) begin
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SHIFT_LO: begin
        if (cnt_zero) begin
          if (bit_q == 4'd0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_SHIFT_HI;
            cnt_d   = DIV_LD;
            bit_d   = bit_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = IDLE_LD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      shreg_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign cs_n           = !frame_active;
  assign sclk           = (state_q == ST_SHIFT_HI);
  assign copi           = frame_active ? shreg_q[15] : 1'b0;
  assign host.req_ready = (state_q == ST_IDLE);
  assign host.busy      = (state_q != ST_IDLE);
  assign host.done      = done_q;

`ifdef SPI_CTRL_READBACK_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;

  // cipo is taken on the last clk of each high phase of the data bits.
  always_comb begin
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    if (accept) begin
      rx_d = 8'd0;
    end else if ((state_q == ST_SHIFT_HI) && cnt_zero && (bit_q <= 4'd7)) begin
      rx_d = {rx_q[6:0], cipo};
    end
    if ((state_q == ST_HOLD) && cnt_zero) begin
      rd_data_d = rx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q      <= 8'd0;
      rd_data_q <= 8'd0;
    end else begin
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench: two controllers (default and minimum timing) against a bus-level
// peripheral model that rebuilds frames from cs_n/sclk/copi and keeps a register file.
module tb_spi_reg_controller;

  localparam int D0 = 4, S0 = 4, H0 = 4, I0 = 4;
  localparam int D1 = 2, S1 = 1, H1 = 1, I1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;

  spi_reg_controller_if ifc0 ();
  spi_reg_controller_if ifc1 ();

  logic       vld [2];
  logic [6:0] adr [2];
  logic [7:0] dat [2];
  logic       csw [2];
  logic       sclkw [2];
  logic       copiw [2];
  logic       donew [2];
  logic       readyw [2];
  logic       busyw [2];

  assign ifc0.req_valid = vld[0];
  assign ifc0.req_addr  = adr[0];
  assign ifc0.req_data  = dat[0];
  assign ifc1.req_valid = vld[1];
  assign ifc1.req_addr  = adr[1];
  assign ifc1.req_data  = dat[1];
  assign donew[0]  = ifc0.done;
  assign donew[1]  = ifc1.done;
  assign readyw[0] = ifc0.req_ready;
  assign readyw[1] = ifc1.req_ready;
  assign busyw[0]  = ifc0.busy;
  assign busyw[1]  = ifc1.busy;

`ifdef SPI_CTRL_READBACK_EN
  logic       cipo_r [2];
  logic [7:0] rdw [2];
`endif

  spi_reg_controller #(.CLK_DIV(D0), .CS_SETUP(S0), .CS_HOLD(H0), .CS_IDLE(I0)) u0 (
    .clk     (clk),
    .rst_n   (rst_n0),
    .host    (ifc0),
`ifdef SPI_CTRL_READBACK_EN
    .cipo    (cipo_r[0]),
    .rd_data (rdw[0]),
`endif
    .cs_n    (csw[0]),
    .sclk    (sclkw[0]),
    .copi    (copiw[0])
  );

  spi_reg_controller #(.CLK_DIV(D1), .CS_SETUP(S1), .CS_HOLD(H1), .CS_IDLE(I1)) u1 (
    .clk     (clk),
    .rst_n   (rst_n1),
    .host    (ifc1),
`ifdef SPI_CTRL_READBACK_EN
    .cipo    (cipo_r[1]),
    .rd_data (rdw[1]),
`endif
    .cs_n    (csw[1]),
    .sclk    (sclkw[1]),
    .copi    (copiw[1])
  );

  int checks = 0;
  int errors = 0;

  // Bus-level peripheral model state, one set per controller.
  int          lowcnt [2], gapcnt [2], rises [2], hi_len [2], lo_len [2];
  int          stab_err [2], tim_err [2], rdy_err [2], done_cnt [2], nframes [2];
  int          last_low [2], last_gap [2], last_bits [2];
  logic [15:0] shr [2], last_frame [2];
  logic        prev_cs [2], prev_sclk [2], prev_copi [2], rise_copi [2];
  logic [7:0]  pregs [2][128];
  logic [7:0]  exp_regs [2][128];
  logic [7:0]  rb_byte [2];
  logic [7:0]  rd_at_done [2];

  function automatic int divk(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int exp_low(input int k);
    return (k == 0) ? (S0 + 32 * D0 + H0) : (S1 + 32 * D1 + H1);
  endfunction

  function automatic int exp_lat(input int k);
    return (k == 0) ? (1 + S0 + 32 * D0 + H0 + I0) : (1 + S1 + 32 * D1 + H1 + I1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (donew[k] === 1'b1) begin
        done_cnt[k]++;
`ifdef SPI_CTRL_READBACK_EN
        rd_at_done[k] = rdw[k];
`endif
      end
      if (busyw[k] === 1'b1 && readyw[k] !== 1'b0) rdy_err[k]++;
      if (csw[k] === 1'b0) begin
        if (prev_cs[k]) begin
          last_gap[k] = gapcnt[k];
          lowcnt[k]   = 0;
          rises[k]    = 0;
        end
        lowcnt[k]++;
        if (sclkw[k] === 1'b1 && !prev_sclk[k]) begin
          if (rises[k] > 0 && lo_len[k] != divk(k)) tim_err[k]++;
          rises[k]++;
          shr[k]       = {shr[k][14:0], copiw[k]};
          rise_copi[k] = copiw[k];
          if (copiw[k] !== prev_copi[k]) stab_err[k]++;
          hi_len[k] = 1;
`ifdef SPI_CTRL_READBACK_EN
          cipo_r[k] = (rises[k] >= 9) ? rb_byte[k][16 - rises[k]] : 1'b0;
`endif
        end else if (sclkw[k] === 1'b1) begin
          hi_len[k]++;
          if (copiw[k] !== rise_copi[k]) stab_err[k]++;
        end else begin
          if (prev_sclk[k]) begin
            if (hi_len[k] != divk(k)) tim_err[k]++;
            lo_len[k] = 0;
          end
          lo_len[k]++;
        end
      end else if (csw[k] === 1'b1) begin
        if (!prev_cs[k]) begin
          last_low[k]   = lowcnt[k];
          last_bits[k]  = rises[k];
          last_frame[k] = shr[k];
          nframes[k]++;
          gapcnt[k] = 0;
          if (rises[k] == 16 && shr[k][15]) pregs[k][shr[k][14:8]] = shr[k][7:0];
        end
        // Only the controller's own gap counts; the IDLE acceptance cycle is not busy.
        if (busyw[k] === 1'b1) gapcnt[k]++;
        if (sclkw[k] !== 1'b0) stab_err[k]++;
      end
      prev_cs[k]   = (csw[k] === 1'b0) ? 1'b0 : 1'b1;
      prev_sclk[k] = (sclkw[k] === 1'b1);
      prev_copi[k] = copiw[k];
    end
  end

  task automatic wait_ready(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (readyw[k] !== 1'b1 && n < 1000);
  endtask

  task automatic do_req(input int k, input logic [6:0] a, input logic [7:0] d);
    int n, f0, d0;
    f0 = nframes[k];
    d0 = done_cnt[k];
    adr[k] = a;
    dat[k] = d;
    vld[k] = 1'b1;
    n = 0;
    while (readyw[k] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 vld[k] = 1'b0;
    wait_ready(k, n);
    exp_regs[k][a] = d;
    $display("req k=%0d addr=0x%02h data=0x%02h frame=0x%04h low=%0d lat=%0d",
             k, a, d, last_frame[k], last_low[k], n);
    check_eq($sformatf("lat%0d", k), 32'(n), 32'(exp_lat(k)));
    check_eq($sformatf("frame%0d", k), 32'(last_frame[k]), 32'({1'b1, a, d}));
    check_eq($sformatf("bits%0d", k), 32'(last_bits[k]), 32'd16);
    check_eq($sformatf("cslow%0d", k), 32'(last_low[k]), 32'(exp_low(k)));
    check_eq($sformatf("frames%0d", k), 32'(nframes[k]), 32'(f0 + 1));
    check_eq($sformatf("dones%0d", k), 32'(done_cnt[k]), 32'(d0 + 1));
    check_eq($sformatf("reg%0d", k), 32'(pregs[k][a]), 32'(exp_regs[k][a]));
`ifdef SPI_CTRL_READBACK_EN
    check_eq($sformatf("rd%0d", k), 32'(rd_at_done[k]), 32'(rb_byte[k]));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, d0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; adr[k] = '0; dat[k] = '0;
      lowcnt[k] = 0; gapcnt[k] = 0; rises[k] = 0; hi_len[k] = 0; lo_len[k] = 0;
      stab_err[k] = 0; tim_err[k] = 0; rdy_err[k] = 0; done_cnt[k] = 0; nframes[k] = 0;
      last_low[k] = 0; last_gap[k] = 0; last_bits[k] = 0;
      shr[k] = '0; last_frame[k] = '0;
      prev_cs[k] = 1'b1; prev_sclk[k] = 1'b0; prev_copi[k] = 1'b0; rise_copi[k] = 1'b0;
      rb_byte[k] = '0; rd_at_done[k] = '0;
`ifdef SPI_CTRL_READBACK_EN
      cipo_r[k] = 1'b0;
`endif
      for (int r = 0; r < 128; r++) begin
        pregs[k][r]    = '0;
        exp_regs[k][r] = '0;
      end
    end
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);
    check_eq("rst_cs_n", 32'(csw[0]), 32'd1);
    check_eq("rst_sclk", 32'(sclkw[0]), 32'd0);
    check_eq("rst_copi", 32'(copiw[0]), 32'd0);
    check_eq("rst_done", 32'(donew[0]), 32'd0);
    check_eq("rst_busy", 32'(busyw[0]), 32'd0);
    check_eq("rst_ready", 32'(readyw[0]), 32'd1);
    check_eq("rst_ready1", 32'(readyw[1]), 32'd1);

    rb_byte[0] = 8'h5A;
    do_req(0, 7'h02, 8'hA5);

    // Back-to-back: valid stays high across both acceptances.
    f0 = nframes[0];
    d0 = done_cnt[0];
    adr[0] = 7'h00; dat[0] = 8'h11; vld[0] = 1'b1;
    @(posedge clk);
    #1 adr[0] = 7'h04; dat[0] = 8'hFF;
    wait_ready(0, n);
    check_eq("b2b_lat", 32'(n), 32'(exp_lat(0)));
    @(posedge clk);
    #1 vld[0] = 1'b0;
    wait_ready(0, n);
    exp_regs[0][0] = 8'h11;
    exp_regs[0][4] = 8'hFF;
    $display("b2b frames=%0d gap=%0d last=0x%04h", nframes[0] - f0, last_gap[0], last_frame[0]);
    check_eq("b2b_frames", 32'(nframes[0]), 32'(f0 + 2));
    check_eq("b2b_dones", 32'(done_cnt[0]), 32'(d0 + 2));
    check_eq("b2b_gap", 32'(last_gap[0]), 32'(I0));
    check_eq("b2b_frame2", 32'(last_frame[0]), 32'h84FF);
    check_eq("b2b_reg0", 32'(pregs[0][0]), 32'(exp_regs[0][0]));
    check_eq("b2b_reg4", 32'(pregs[0][4]), 32'(exp_regs[0][4]));

    // Requests toggled while busy must be ignored.
    f0 = nframes[0];
    d0 = done_cnt[0];
    adr[0] = 7'h10; dat[0] = 8'h33; vld[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      vld[0] = ((i % 2) == 0);
      adr[0] = 7'h55;
      dat[0] = 8'h77;
      @(posedge clk);
      #1;
    end
    vld[0] = 1'b0;
    wait_ready(0, n);
    repeat (200) @(negedge clk);
    exp_regs[0][7'h10] = 8'h33;
    $display("busy-toggle frames=%0d last=0x%04h", nframes[0] - f0, last_frame[0]);
    check_eq("ign_frame", 32'(last_frame[0]), 32'h9033);
    check_eq("ign_frames", 32'(nframes[0]), 32'(f0 + 1));
    check_eq("ign_dones", 32'(done_cnt[0]), 32'(d0 + 1));
    check_eq("ign_reg55", 32'(pregs[0][7'h55]), 32'(exp_regs[0][7'h55]));

    // Reset during the 7th sclk high phase abandons the frame.
    f0 = nframes[0];
    d0 = done_cnt[0];
    adr[0] = 7'h30; dat[0] = 8'h99; vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    n = 0;
    while (rises[0] != 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rst_n0 = 1'b0;
    @(posedge clk);
    #1 rst_n0 = 1'b1;
    @(negedge clk);
    $display("mid-frame reset cs_n=%0b sclk=%0b busy=%0b", csw[0], sclkw[0], busyw[0]);
    check_eq("mrst_cs_n", 32'(csw[0]), 32'd1);
    check_eq("mrst_sclk", 32'(sclkw[0]), 32'd0);
    check_eq("mrst_busy", 32'(busyw[0]), 32'd0);
    check_eq("mrst_ready", 32'(readyw[0]), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("mrst_dones", 32'(done_cnt[0]), 32'(d0));
    check_eq("mrst_bits", 32'(last_bits[0]), 32'd7);
    check_eq("mrst_frames", 32'(nframes[0]), 32'(f0 + 1));
    check_eq("mrst_reg30", 32'(pregs[0][7'h30]), 32'(exp_regs[0][7'h30]));
    rb_byte[0] = 8'(($urandom) & 32'hFF);
    do_req(0, 7'h01, 8'h3C);

    for (int i = 0; i < 4; i++) begin
      rb_byte[0] = 8'(($urandom) & 32'hFF);
      do_req(0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 8; i++) begin
      rb_byte[1] = 8'(($urandom) & 32'hFF);
      do_req(1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    end

    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("copi_stable%0d", k), 32'(stab_err[k]), 32'd0);
      check_eq($sformatf("sclk_phase%0d", k), 32'(tim_err[k]), 32'd0);
      check_eq($sformatf("ready_busy%0d", k), 32'(rdy_err[k]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
